counter_access_arbiter: RTL and testbench

//   Shares the single 8-bit counter register block (CtrValue, 2-bit offset read port) between
//   NUM_REQ requesters. Round-robin grant, fixed 3-cycle transaction (IDLE->ACCESS->RESP).

---
 rtl/counter_access_arbiter.sv | 123 ++++++++++++
 tb/tb_counter_access_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_access_arbiter.sv
// counter_access_arbiter: round-robin access arbiter in front of the shared 8-bit counter block.
// Every transaction takes three cycles (IDLE -> ACCESS -> RESP). In ACCESS the arbiter drives the
// counter's WriteEn/ValIn/Offset, and in RESP it returns the read or written value to the winner.
// Optional feature macro: CTR_ARB_PRIO0_EN (requester 0 takes absolute priority in arbitration).
module counter_access_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ-1:0]        ReqWrite,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    input  logic [NUM_REQ*2-1:0]      ReqOffset,
    output logic [NUM_REQ-1:0]        Gnt,
    output logic [NUM_REQ-1:0]        Done,
    output logic [DATA_W-1:0]         RspData,
    output logic                      Busy,
    output logic                      CtrWriteEn,
    output logic [DATA_W-1:0]         CtrValIn,
    output logic [1:0]                CtrOffset,
    input  logic [DATA_W-1:0]         CtrValOut
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    win;
    logic                wr_q;
    logic [DATA_W-1:0]   data_q;

    logic                sel_found;
    logic [PTR_W-1:0]    sel_idx;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_data;
    logic [1:0]          sel_off;
    logic [NUM_REQ-1:0]  sel_onehot;
    int unsigned         cand;

    // Winner select: first active request at or after the round-robin pointer, modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!sel_found && Req[PTR_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(cand);
            end
        end
`ifdef CTR_ARB_PRIO0_EN
        if (Req[0]) begin
            sel_found = 1'b1;
            sel_idx   = '0;
        end
`endif
        sel_write  = ReqWrite[sel_idx];
        sel_data   = ReqData[32'(sel_idx) * DATA_W +: DATA_W];
        sel_off    = ReqOffset[32'(sel_idx) * 2 +: 2];
        sel_onehot = NUM_REQ'(1) << sel_idx;
    end

    // Transaction FSM with registered grant, response and counter-port outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            win        <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            Gnt        <= '0;
            Done       <= '0;
            RspData    <= '0;
            Busy       <= 1'b0;
            CtrWriteEn <= 1'b0;
            CtrValIn   <= '0;
            CtrOffset  <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        state      <= ST_ACCESS;
                        win        <= sel_idx;
                        wr_q       <= sel_write;
                        data_q     <= sel_data;
                        Gnt        <= sel_onehot;
                        Busy       <= 1'b1;
                        CtrWriteEn <= sel_write;
                        CtrValIn   <= sel_write ? sel_data : '0;
                        CtrOffset  <= sel_write ? 2'b00 : sel_off;
                    end
                end
                ST_ACCESS: begin
                    state      <= ST_RESP;
                    Done       <= Gnt;
                    RspData    <= wr_q ? data_q : CtrValOut;
                    CtrWriteEn <= 1'b0;
                    CtrValIn   <= '0;
                    CtrOffset  <= 2'b00;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    Done  <= '0;
                    Gnt   <= '0;
                    Busy  <= 1'b0;
                    ptr   <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Self-checking bench for counter_access_arbiter with a behavioural model of the counter block.
module tb_counter_access_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NR-1:0]     Req;
    logic [NR-1:0]     ReqWrite;
    logic [NR*DW-1:0]  ReqData;
    logic [NR*2-1:0]   ReqOffset;
    logic [NR-1:0]     Gnt;
    logic [NR-1:0]     Done;
    logic [DW-1:0]     RspData;
    logic              Busy;
    logic              CtrWriteEn;
    logic [DW-1:0]     CtrValIn;
    logic [1:0]        CtrOffset;
    logic [DW-1:0]     CtrValOut;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] shadow;
    logic [DW-1:0] ctr_q;
    logic          preload_en = 1'b0;
    logic [DW-1:0] preload_val = '0;

    always #5 Clk = ~Clk;

    counter_access_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .ReqWrite(ReqWrite), .ReqData(ReqData),
        .ReqOffset(ReqOffset), .Gnt(Gnt), .Done(Done), .RspData(RspData), .Busy(Busy),
        .CtrWriteEn(CtrWriteEn), .CtrValIn(CtrValIn), .CtrOffset(CtrOffset), .CtrValOut(CtrValOut)
    );

    function automatic logic [DW-1:0] off_add(input logic [1:0] o);
        case (o)
            2'b01:   return 8'd30;
            2'b10:   return 8'd60;
            default: return 8'd0;
        endcase
    endfunction

    // Counter block model: register written on posedge, combinational offset read.
    always @(posedge Clk) begin
        if (preload_en)      ctr_q <= preload_val;
        else if (CtrWriteEn) ctr_q <= CtrValIn;
    end
    assign CtrValOut = ctr_q + off_add(CtrOffset);

    task automatic preload(input logic [DW-1:0] v);
        preload_en  = 1'b1;
        preload_val = v;
        @(negedge Clk);
        preload_en = 1'b0;
        shadow     = v;
    endtask

    task automatic set_rd(input int i, input logic [1:0] off);
        ReqWrite[i]         = 1'b0;
        ReqOffset[i*2 +: 2] = off;
    endtask

    task automatic set_wr(input int i, input logic [DW-1:0] d);
        ReqWrite[i]         = 1'b1;
        ReqData[i*DW +: DW] = d;
    endtask

    task automatic wait_done(input int limit, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= limit && !got; i++) begin
            @(negedge Clk);
            if (|Done) begin
                got = 1'b1;
                cyc = i;
            end
        end
    endtask

    task automatic pop_exp(output int idx, output logic [DW-1:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            idx = -1;
            d   = 'x;
        end else begin
            e   = exp_q.pop_front();
            idx = e.idx;
            d   = e.data;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Req   = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            n_checks++;
            if ({Gnt, Done, CtrWriteEn, Busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: got gnt=%b done=%b we=%b busy=%b, expected all 0",
                         c, Gnt, Done, CtrWriteEn, Busy);
            end
        end
        n_checks++;
        if (RspData !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rspdata: got %h expected 00", RspData);
        end
        Reset = 1'b1;
        Req   = '0;
        @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || Gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b gnt=%b expected 0/0000", Busy, Gnt);
        end
    endtask

    task automatic test_single_read();
        int            idx;
        logic [DW-1:0] d;
        preload(8'h10);
        set_rd(2, 2'b10);
        Req = 4'b0100;
        exp_q.push_back('{2, shadow + off_add(2'b10)});
        @(negedge Clk);
        n_checks++;
        if (Gnt !== 4'b0100 || Busy !== 1'b1 || CtrOffset !== 2'b10 || CtrWriteEn !== 1'b0 || Done !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_access: got gnt=%b busy=%b off=%b we=%b done=%b expected 0100/1/10/0/0000",
                     Gnt, Busy, CtrOffset, CtrWriteEn, Done);
        end
        @(negedge Clk);
        pop_exp(idx, d);
        n_checks++;
        if (Gnt !== 4'b0100 || Done !== (4'(1) << idx) || RspData !== d) begin
            n_fail++;
            $display("FAIL single_resp: got gnt=%b done=%b rsp=%h expected 0100/%b/%h",
                     Gnt, Done, RspData, 4'(1) << idx, d);
        end
        Req = '0;
        @(negedge Clk);
        n_checks++;
        if (Gnt !== 4'b0000 || Busy !== 1'b0 || Done !== 4'b0000 || CtrOffset !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: got gnt=%b busy=%b done=%b off=%b expected 0000/0/0000/00",
                     Gnt, Busy, Done, CtrOffset);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]    offs [NR];
        bit            got;
        int            cyc;
        int            idx;
        logic [DW-1:0] d;
        offs = '{2'b00, 2'b01, 2'b10, 2'b11};
        do_reset();
        preload(8'h20);
        for (int i = 0; i < NR; i++) set_rd(i, offs[i]);
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back('{k % NR, shadow + off_add(offs[k % NR])});
        for (int k = 0; k < 5; k++) begin
            wait_done(8, got, cyc);
            pop_exp(idx, d);
            n_checks++;
            if (!got || cyc != ((k == 0) ? 2 : 3)) begin
                n_fail++;
                $display("FAIL rr_timing txn%0d: got done=%0d after %0d cycles expected %0d", k, got, cyc, (k == 0) ? 2 : 3);
            end
            n_checks++;
            if (Done !== (4'(1) << idx) || RspData !== d) begin
                n_fail++;
                $display("FAIL rr_order txn%0d: got done=%b rsp=%h expected %b/%h", k, Done, RspData, 4'(1) << idx, d);
            end
        end
        Req = '0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || Done !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_quiesce: got busy=%b done=%b expected 0/0000", Busy, Done);
        end
    endtask

    task automatic test_write_read();
        bit            got;
        int            cyc;
        int            idx;
        logic [DW-1:0] d;
        set_wr(1, 8'hF0);
        Req = 4'b0010;
        exp_q.push_back('{1, 8'hF0});
        shadow = 8'hF0;
        wait_done(8, got, cyc);
        pop_exp(idx, d);
        n_checks++;
        if (!got || Done !== (4'(1) << idx) || RspData !== d) begin
            n_fail++;
            $display("FAIL write_resp: got done=%b rsp=%h expected %b/%h", Done, RspData, 4'(1) << idx, d);
        end
        set_rd(3, 2'b01);
        Req = 4'b1000;
        exp_q.push_back('{3, shadow + off_add(2'b01)});
        wait_done(8, got, cyc);
        pop_exp(idx, d);
        n_checks++;
        if (!got || Done !== (4'(1) << idx) || RspData !== d) begin
            n_fail++;
            $display("FAIL read_after_write: got done=%b rsp=%h expected %b/%h", Done, RspData, 4'(1) << idx, d);
        end
        Req = '0;
        @(negedge Clk);
    endtask

    task automatic test_reset_abort();
        bit            saw_done;
        bit            got;
        int            cyc;
        int            idx;
        logic [DW-1:0] d;
        set_wr(1, 8'h55);
        Req = 4'b0010;
        @(negedge Clk);
        n_checks++;
        if (Gnt !== 4'b0010 || CtrWriteEn !== 1'b1 || CtrValIn !== 8'h55) begin
            n_fail++;
            $display("FAIL abort_access: got gnt=%b we=%b valin=%h expected 0010/1/55", Gnt, CtrWriteEn, CtrValIn);
        end
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Gnt !== 4'b0000 || CtrWriteEn !== 1'b0 || Done !== 4'b0000 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: got gnt=%b we=%b done=%b busy=%b expected 0000/0/0000/0",
                     Gnt, CtrWriteEn, Done, Busy);
        end
        Reset = 1'b1;
        Req   = '0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if (|Done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_no_done: got a Done pulse expected none");
        end
        preload(8'h01);
        set_rd(2, 2'b00);
        Req = 4'b0100;
        exp_q.push_back('{2, shadow});
        @(negedge Clk);
        n_checks++;
        if (Gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL abort_idle_regrant: got gnt=%b expected 0100", Gnt);
        end
        wait_done(8, got, cyc);
        pop_exp(idx, d);
        n_checks++;
        if (!got || Done !== (4'(1) << idx) || RspData !== d) begin
            n_fail++;
            $display("FAIL abort_followup: got done=%b rsp=%h expected %b/%h", Done, RspData, 4'(1) << idx, d);
        end
        Req = '0;
        @(negedge Clk);
    endtask

    task automatic test_priority();
        bit            got;
        int            cyc;
        int            idx;
        logic [DW-1:0] d;
        int            first;
        int            second;
        // Pointer is 3 here; a lone grant to requester 1 moves it to 2.
        preload(8'h05);
        set_rd(1, 2'b00);
        Req = 4'b0010;
        exp_q.push_back('{1, shadow});
`ifdef CTR_ARB_PRIO0_EN
        first  = 0;
        second = 2;
`else
        first  = 2;
        second = 0;
`endif
        set_rd(0, 2'b01);
        set_rd(2, 2'b10);
        exp_q.push_back('{first,  shadow + ((first == 0) ? 8'd30 : 8'd60)});
        exp_q.push_back('{second, shadow + ((second == 0) ? 8'd30 : 8'd60)});
        wait_done(8, got, cyc);
        pop_exp(idx, d);
        n_checks++;
        if (!got || Done !== (4'(1) << idx) || RspData !== d) begin
            n_fail++;
            $display("FAIL prio_setup: got done=%b rsp=%h expected %b/%h", Done, RspData, 4'(1) << idx, d);
        end
        Req = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            wait_done(8, got, cyc);
            pop_exp(idx, d);
            n_checks++;
            if (!got || Done !== (4'(1) << idx) || RspData !== d) begin
                n_fail++;
                $display("FAIL prio_order txn%0d: got done=%b rsp=%h expected %b/%h", k, Done, RspData, 4'(1) << idx, d);
            end
            Req = Req & ~Done;
        end
        Req = '0;
        @(negedge Clk);
    endtask

    initial begin
        Reset     = 1'b0;
        Req       = '0;
        ReqWrite  = '0;
        ReqData   = '0;
        ReqOffset = '0;
        shadow    = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_reset_abort();
        test_priority();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
